// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - register offsets, interrupt codes and reset constants shared by intr_ctrl and the CSR decode
package intr_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_EXT_CLR     = 5'h10;
  localparam logic [4:0] OFF_STATUS      = 5'h14;

  typedef enum logic [3:0] {
    INTR_NONE  = 4'd0,
    INTR_TIMER = 4'd1,
    INTR_EXT   = 4'd2
  } intr_code_e;

  // All-ones compare value keeps the timer quiet until software programs it.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/irq_edge_sync.sv
// rtl/irq_edge_sync.sv - optional 2-flop synchronizer (INTR_CTRL_SYNC_EN) and rising-edge detector
module irq_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  output logic o_rise
);

  logic w_cond;
  logic r_prev;

`ifdef INTR_CTRL_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cond = r_sync2;
`else
  // Source is already in the clk domain.
  assign w_cond = i_irq;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_cond;
    end
  end

  assign o_rise = w_cond & ~r_prev;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - mtime/mtimecmp timer plus edge-captured external IRQ; sync stage under INTR_CTRL_SYNC_EN
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ext_irq,
  output logic [3:0]  interrupt
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_ext_pend;
  intr_code_e    r_code;

  logic       w_tick;
  logic       w_tmr_pend;
  logic       w_rise;
  logic       w_wr_mtime_lo;
  logic       w_wr_mtime_hi;
  logic       w_wr_cmp_lo;
  logic       w_wr_cmp_hi;
  logic       w_wr_ext_clr;
  intr_code_e w_code;

  irq_edge_sync u_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_irq  (ext_irq),
    .o_rise (w_rise)
  );

  assign w_wr_mtime_lo = wr_en && (addr == OFF_MTIME_LO);
  assign w_wr_mtime_hi = wr_en && (addr == OFF_MTIME_HI);
  assign w_wr_cmp_lo   = wr_en && (addr == OFF_MTIMECMP_LO);
  assign w_wr_cmp_hi   = wr_en && (addr == OFF_MTIMECMP_HI);
  assign w_wr_ext_clr  = wr_en && (addr == OFF_EXT_CLR) && wdata[0];

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_tmr_pend = (r_mtime >= r_mtimecmp);

  // The prescaler keeps running through mtime writes so software can't skew the tick phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= wdata;
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= MTIMECMP_RST;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= wdata;
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= wdata;
    end
  end

  // A new edge outranks a same-cycle clear so no request is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_pend <= 1'b0;
    end else if (w_rise) begin
      r_ext_pend <= 1'b1;
    end else if (w_wr_ext_clr) begin
      r_ext_pend <= 1'b0;
    end
  end

  always_comb begin
    w_code = INTR_NONE;
    if (r_ext_pend) begin
      w_code = INTR_EXT;
    end else if (w_tmr_pend) begin
      w_code = INTR_TIMER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= INTR_NONE;
    end else begin
      r_code <= w_code;
    end
  end

  assign interrupt = r_code;

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        OFF_MTIME_LO:    rdata = r_mtime[31:0];
        OFF_MTIME_HI:    rdata = r_mtime[63:32];
        OFF_MTIMECMP_LO: rdata = r_mtimecmp[31:0];
        OFF_MTIMECMP_HI: rdata = r_mtimecmp[63:32];
        OFF_STATUS:      rdata = {30'd0, r_ext_pend, w_tmr_pend};
        default:         rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - model-checked bench for intr_ctrl with PRESCALE 1 and 4 instances on a shared bus
module tb_intr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic        ext_irq = 1'b0;
  logic [4:0]  addr    = '0;
  logic [31:0] wdata   = '0;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  int_a, int_b;

  intr_ctrl #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ext_irq(ext_irq), .interrupt(int_a)
  );

  intr_ctrl #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ext_irq(ext_irq), .interrupt(int_b)
  );

`ifdef INTR_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_ext  [2];
  logic [3:0]  m_int  [2];
  int unsigned m_cyc  [2];
  logic [2:0]  m_hist = '0;
  bit          started = 1'b0;

  function automatic int pre(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [4:0] a);
    case (a)
      5'h00:   return m_time[i][31:0];
      5'h04:   return m_time[i][63:32];
      5'h08:   return m_cmp[i][31:0];
      5'h0C:   return m_cmp[i][63:32];
      5'h14:   return {30'd0, m_ext[i], (m_time[i] >= m_cmp[i])};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] cur;
    logic       rise;
    cur  = {m_hist, ext_irq};
    rise = cur[D] & ~cur[D+1];
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_time[i] = 64'd0;
        m_cmp[i]  = {64{1'b1}};
        m_ext[i]  = 1'b0;
        m_int[i]  = 4'd0;
        m_cyc[i]  = 0;
      end else begin
        m_int[i] = m_ext[i] ? 4'd2 : ((m_time[i] >= m_cmp[i]) ? 4'd1 : 4'd0);
        if (rise) m_ext[i] = 1'b1;
        else if (wr_en && addr == 5'h10 && wdata[0]) m_ext[i] = 1'b0;
        if (wr_en && addr == 5'h00) m_time[i][31:0] = wdata;
        else if (wr_en && addr == 5'h04) m_time[i][63:32] = wdata;
        else if (m_cyc[i] % pre(i) == pre(i) - 1) m_time[i] = m_time[i] + 64'd1;
        if (wr_en && addr == 5'h08) m_cmp[i][31:0] = wdata;
        else if (wr_en && addr == 5'h0C) m_cmp[i][63:32] = wdata;
        m_cyc[i]++;
      end
    end
    m_hist  = rst ? 3'b000 : cur[2:0];
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("int_a", int_a, m_int[0]);
      chk("int_b", int_b, m_int[1]);
      chk("rdata_a", rdata_a, rd_en ? m_read(0, addr) : 32'd0);
      chk("rdata_b", rdata_b, rd_en ? m_read(1, addr) : 32'd0);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en = 1'b1;
    addr  = a;
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    wait_edges(3);
    rst = 1'b0;
    chk("int_a_after_reset", int_a, 4'd0);
    rd(5'h08); chk("cmp_lo_reset_a", rdata_a, 32'hFFFF_FFFF); chk("cmp_lo_reset_b", rdata_b, 32'hFFFF_FFFF);
    rd(5'h0C); chk("cmp_hi_reset_a", rdata_a, 32'hFFFF_FFFF); chk("cmp_hi_reset_b", rdata_b, 32'hFFFF_FFFF);
    rd(5'h14); chk("status_reset_a", rdata_a, 32'd0);
    rd_en = 1'b0;

    wait_edges(40);
    rd(5'h00); chk("prescale4_40cyc", rdata_b, 32'd10); chk("prescale1_40cyc", rdata_a, 32'd40);
    bus_write(5'h00, 32'd100);
    rd(5'h00); chk("mtime_wr_b", rdata_b, 32'd100); chk("mtime_wr_a", rdata_a, 32'd100);
    wait_edges(3);
    rd(5'h00); chk("mtime_after_wr_b", rdata_b, 32'd101); chk("mtime_after_wr_a", rdata_a, 32'd103);

    bus_write(5'h00, 32'd0);
    bus_write(5'h0C, 32'd0);
    bus_write(5'h08, 32'd10);
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      rd(5'h00);
      if (rdata_a == 32'd10) begin
        seen = 1'b1;
        chk("int_a_at_mtime10", int_a, 4'd0);
        wait_edges(1);
        chk("int_a_timer_fire", int_a, 4'd1);
      end else begin
        wait_edges(1);
      end
    end
    chk("mtime_reached_10", seen, 1'b1);
    bus_write(5'h08, 32'hFFFF_FFFF);
    chk("int_a_timer_hold", int_a, 4'd1);
    wait_edges(1);
    chk("int_a_timer_clear", int_a, 4'd0);

    ext_irq = 1'b1;
    wait_edges(D + 1);
    chk("int_a_ext_early", int_a, 4'd0);
    wait_edges(1);
    chk("int_a_ext", int_a, 4'd2); chk("int_b_ext", int_b, 4'd2);
    wait_edges(5 - (D + 2));
    ext_irq = 1'b0;
    wait_edges(4);
    rd(5'h14); chk("status_ext_a", rdata_a, 32'd2);
    chk("int_a_ext_held", int_a, 4'd2);
    bus_write(5'h10, 32'd1);
    chk("int_a_ext_clr_lag", int_a, 4'd2);
    wait_edges(1);
    chk("int_a_ext_cleared", int_a, 4'd0);
    rd(5'h14); chk("status_cleared_a", rdata_a, 32'd0);

    bus_write(5'h08, 32'd0);
    wait_edges(1);
    chk("int_a_timer_prio", int_a, 4'd1);
    ext_irq = 1'b1;
    wait_edges(D + 2);
    chk("int_a_prio_ext", int_a, 4'd2); chk("int_b_prio_ext", int_b, 4'd2);
    ext_irq = 1'b0;
    wait_edges(2);
    bus_write(5'h10, 32'd1);
    wait_edges(1);
    chk("int_a_back_to_timer", int_a, 4'd1);

    ext_irq = 1'b1;
    if (D == 0) begin wr_en = 1'b1; addr = 5'h10; wdata = 32'd1; end
    for (int j = 1; j <= D; j++) begin
      wait_edges(1);
      if (j == D) begin wr_en = 1'b1; addr = 5'h10; wdata = 32'd1; end
    end
    wait_edges(1);
    wr_en = 1'b0;
    rd(5'h14); chk("ext_set_wins_a", rdata_a[1], 1'b1); chk("ext_set_wins_b", rdata_b[1], 1'b1);

    ext_irq = 1'b0;
    wait_edges(3);
    bus_write(5'h10, 32'd1);
    wait_edges(1);
    bus_write(5'h04, 32'hFFFF_FFFF);
    bus_write(5'h00, 32'hFFFF_FFFF);
    rd(5'h00); chk("wrap_pre_a", rdata_a, 32'hFFFF_FFFF);
    wait_edges(1);
    rd(5'h00); chk("wrap_lo_a", rdata_a, 32'd0);
    rd(5'h04); chk("wrap_hi_a", rdata_a, 32'd0);
    chk("wrap_int_a", int_a, 4'd1);
    wait_edges(1);
    chk("wrap_int_a_next", int_a, 4'd1);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
      wr_en = ($urandom_range(0, 3) == 0);
      rd_en = $urandom_range(0, 1);
      addr  = 5'($urandom_range(0, 7) * 4);
      case ($urandom_range(0, 3))
        0:       wdata = $urandom;
        1:       wdata = 32'd0;
        default: wdata = $urandom_range(0, 80);
      endcase
      wait_edges(1);
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wait_edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
